maxnet_controller: RTL and testbench

- Sequencing FSM for the four-lane Maxnet competition datapath: loads X1..X4 into the temp registers, then repeatedly reloads the activation-function outputs until the datapath's done flag reports a single surviving lane.
- Waits a configurable number of cycles after every load so the pipelined PUs settle before done is trusted.
- Bounds the number of iterations and signals timeout if the bound is hit.
- Presents the outcome through a start/ready and valid/ack handshake to the surrounding top level.

---
 rtl/maxnet_controller.sv | 121 ++++++++++++
 tb/tb_maxnet_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
`timescale 1ns/1ps
// maxnet_controller
// Sequencing FSM for the four-lane Maxnet competition datapath. Loads the
// X inputs into the temp registers, waits PU_LAT cycles for the PUs to
// settle, then keeps reloading the AF outputs until the datapath reports a
// single survivor (done) or MAX_ITER updates have been spent (timeout).
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start / ready     request a competition / controller idle
//   abort             cancel a running competition (no effect when idle/done)
//   done              datapath flag: at most one lane nonzero
//   valid / result_ack  result available / consumer accepts it
//   ld_t, sel_t       temp-register load enable and source (1 = X, 0 = AF)
//   busy              LOAD, SETTLE or UPDATE in progress
//   timeout           qualifies valid: run ended on the iteration bound
//   iter_count        UPDATE loads in the current/last run
module maxnet_controller #(
    parameter int PU_LAT   = 2,
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              done,
    input  logic              result_ack,
    output logic              ld_t,
    output logic              sel_t,
    output logic              ready,
    output logic              busy,
    output logic              valid,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Counter starts at PU_LAT-1 so SETTLE lasts exactly PU_LAT cycles.
    localparam logic [3:0]        SETTLE_INIT = 4'(PU_LAT - 1);
    localparam logic [ITER_W-1:0] ITER_MAX    = ITER_W'(MAX_ITER);

    logic [2:0] state;
    logic [3:0] settle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            iter_count <= '0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        iter_count <= '0;
                        timeout    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        timeout <= 1'b0;
                    end else begin
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_INIT;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        timeout <= 1'b0;
                    end else if (settle_cnt != 4'd0) begin
                        // done is not trusted until the pipeline has drained
                        settle_cnt <= settle_cnt - 4'd1;
                    end else if (done) begin
                        // a winner beats the iteration bound on the same cycle
                        state   <= S_DONE;
                        timeout <= 1'b0;
                    end else if (iter_count == ITER_MAX) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                    end else begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        timeout <= 1'b0;
                    end else begin
                        iter_count <= iter_count + ITER_W'(1);
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_INIT;
                    end
                end
                S_DONE: begin
                    if (result_ack) begin
                        state   <= S_IDLE;
                        timeout <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // abort suppresses the load so an aborted run leaves the temps untouched
    assign ld_t  = ((state == S_LOAD) || (state == S_UPDATE)) && !abort;
    assign sel_t = (state == S_LOAD);
    assign ready = (state == S_IDLE);
    assign busy  = (state == S_LOAD) || (state == S_SETTLE) || (state == S_UPDATE);
    assign valid = (state == S_DONE);

endmodule

// File: tb/tb_maxnet_controller.sv
`timescale 1ns/1ps
module tb_maxnet_controller;
    localparam int P    = 2;
    localparam int MAXI = 15;
    localparam int IW   = 4;

    logic clk = 1'b0;
    logic rst, start, abort, result_ack, done;
    logic ld_t, sel_t, ready, busy, valid, timeout;
    logic [IW-1:0] iter_count;

    // done source: 0 = d_drv, 1 = model iterations >= done_tgt,
    // 2 = high only on the final decision cycle at the iteration bound
    logic d_drv = 1'b0;
    int   done_sel = 0;
    int   done_tgt = 0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    maxnet_controller #(.PU_LAT(P), .MAX_ITER(MAXI), .ITER_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .done(done),
        .result_ack(result_ack), .ld_t(ld_t), .sel_t(sel_t), .ready(ready),
        .busy(busy), .valid(valid), .timeout(timeout), .iter_count(iter_count)
    );

    // Behavioural model: a run is a sequence of blocks of 1+P cycles.
    // Block k starts with a load (k=0 from X, k>0 from AF) and ends with a
    // decision taken with k iterations performed.
    int m_mode = 0;   // 0 idle, 1 running, 2 result held
    int m_e    = 1;   // 1-based cycle index inside the run
    int m_iter = 0;
    bit m_to   = 1'b0;
    int m_k, m_pos;
    assign m_k   = (m_e - 1) / (P + 1);
    assign m_pos = (m_e - 1) % (P + 1);

    assign done = (done_sel == 0) ? d_drv :
                  (done_sel == 1) ? (m_iter >= done_tgt) :
                  (m_mode == 1 && m_pos == P && m_k == MAXI);

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= 0; m_iter <= 0; m_to <= 1'b0; m_e <= 1;
        end else begin
            case (m_mode)
                0: if (start) begin m_mode <= 1; m_e <= 1; m_iter <= 0; end
                1: begin
                    if (abort) begin
                        m_mode <= 0; m_to <= 1'b0;
                    end else begin
                        if (m_pos == 0 && m_k > 0) m_iter <= m_k;
                        if (m_pos == P) begin
                            if (done)              begin m_mode <= 2; m_to <= 1'b0; end
                            else if (m_k == MAXI)  begin m_mode <= 2; m_to <= 1'b1; end
                            else m_e <= m_e + 1;
                        end else begin
                            m_e <= m_e + 1;
                        end
                    end
                end
                default: if (result_ack) begin m_mode <= 0; m_to <= 1'b0; end
            endcase
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready",   ready,   m_mode == 0);
            chk("busy",    busy,    m_mode == 1);
            chk("valid",   valid,   m_mode == 2);
            chk("ld_t",    ld_t,    m_mode == 1 && m_pos == 0 && !abort);
            chk("sel_t",   sel_t,   m_mode == 1 && m_e == 1);
            chk("timeout", timeout, m_to);
            chk("iter",    iter_count, m_iter);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start, return the cycle valid is first seen (start cycle = 0),
    // the number of AF reloads seen and whether cycle 1 was an X load.
    task automatic run_to_valid(output int n, output int n_upd, output int ld1);
        n_upd = 0; ld1 = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 1;
        while (n < 300) begin
            @(negedge clk);
            if (valid) break;
            if (n == 1) ld1 = int'(ld_t && sel_t);
            if (ld_t && !sel_t) n_upd++;
            tick;
            n++;
        end
        if (n >= 300) chk("valid_timeout", 0, 1);
    endtask

    task automatic ack_it;
        tick;
        result_ack = 1'b1;
        tick;
        result_ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        @(negedge clk);
        chk({nm, "_ready"}, ready, 1);
        chk({nm, "_busy"},  busy,  0);
        chk({nm, "_valid"}, valid, 0);
        chk({nm, "_ld_t"},  ld_t,  0);
        chk({nm, "_sel_t"}, sel_t, 0);
        chk({nm, "_to"},    timeout, 0);
        chk({nm, "_iter"},  iter_count, 0);
    endtask

    int n, nu, l1, guard;

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b0; result_ack = 1'b0;
        repeat (2) tick;
        cmp_en = 1'b1;
        chk_reset_vals("rst");
        tick;
        rst = 1'b0; start = 1'b0;
        tick;

        // immediate winner
        d_drv = 1'b1;
        run_to_valid(n, nu, l1);
        chk("imm_lat", n, 4);
        chk("imm_load", l1, 1);
        chk("imm_iter", iter_count, 0);
        chk("imm_to", timeout, 0);
        ack_it;
        d_drv = 1'b0;

        // three-iteration convergence, then a held result with start ignored
        done_sel = 1; done_tgt = 3;
        run_to_valid(n, nu, l1);
        chk("conv_lat", n, 13);
        chk("conv_upd", nu, 3);
        chk("conv_iter", iter_count, 3);
        chk("conv_to", timeout, 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            start = (i % 2 == 0);
            @(negedge clk);
            chk("hold_valid", valid, 1);
            chk("hold_iter", iter_count, 3);
        end
        tick;
        start = 1'b0;
        result_ack = 1'b1;
        tick;
        result_ack = 1'b0;
        @(negedge clk);
        chk("ack_ready", ready, 1);
        chk("ack_iter", iter_count, 3);
        done_sel = 0;

        // iteration bound
        run_to_valid(n, nu, l1);
        chk("to_lat", n, 49);
        chk("to_upd", nu, 15);
        chk("to_iter", iter_count, 15);
        chk("to_flag", timeout, 1);
        ack_it;

        // winner on the very last decision cycle
        done_sel = 2;
        run_to_valid(n, nu, l1);
        chk("last_lat", n, 49);
        chk("last_iter", iter_count, 15);
        chk("last_flag", timeout, 0);
        ack_it;
        done_sel = 0;

        // abort in an UPDATE cycle
        start = 1'b1;
        tick;
        start = 1'b0;
        guard = 0;
        while (!(m_mode == 1 && m_pos == 0 && m_k > 0) && guard < 100) begin
            tick;
            guard++;
        end
        chk("abort_reach", int'(guard < 100), 1);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_ld", ld_t, 0);
        tick;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_valid", valid, 0);

        // reset in the middle of SETTLE
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset_vals("mid_rst");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick;
            start      = ($urandom_range(0, 3) == 0);
            abort      = ($urandom_range(0, 49) == 0);
            d_drv      = ($urandom_range(0, (i < 2000) ? 4 : 12) == 0);
            result_ack = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 299) == 0);
        end
        tick;
        rst = 1'b0; start = 1'b0; abort = 1'b0; result_ack = 1'b0;
        tick;
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
